// File: rtl/clk_tick_gen.sv
// clk_tick_gen: multi-channel programmable tick / square-wave generator.
// Each channel counts modulo (tc+1), emitting a one-cycle tick at each wrap
// and a registered square wave. A single pending slot takes new terminal
// counts and commits them only at a period boundary, so no output period is
// ever shortened or stretched.
module clk_tick_gen #(
    parameter int              NUM_CH     = 4,
    parameter int              CNT_W      = 18,
    parameter logic [CNT_W-1:0] DEFAULT_TC = CNT_W'((2**18) - 1)
) (
    input  logic                                  clk_vga,
    input  logic                                  rst_n,
    input  logic [NUM_CH-1:0]                     en,
    input  logic                                  sync_clr,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                      cfg_tc,
    output logic [NUM_CH-1:0]                     tick,
    output logic [NUM_CH-1:0]                     clk_out
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    logic [CNT_W-1:0] cnt     [NUM_CH];
    logic [CNT_W-1:0] tc      [NUM_CH];
    logic [CNT_W-1:0] cnt_nxt [NUM_CH];
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] tick_nxt;
    logic [NUM_CH-1:0] clk_nxt;

    logic             pend_v;
    logic [CH_W-1:0]  pend_ch;
    logic [CNT_W-1:0] pend_tc;
    logic             accept;
    logic             apply;

    assign cfg_ready = ~pend_v;

    // Next-state for every channel counter and its registered outputs.
    always_comb begin
        wrap     = '0;
        tick_nxt = '0;
        clk_nxt  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wrap[i]    = en[i] && (cnt[i] == tc[i]);
            cnt_nxt[i] = '0;
            if (!sync_clr && en[i] && !wrap[i]) begin
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
            tick_nxt[i] = wrap[i] && !sync_clr;
            // Low for ceil(P/2) cycles, high for floor(P/2); cnt_nxt is 0 when
            // cleared or disabled, so the compare also yields 0 there.
            clk_nxt[i]  = cnt_nxt[i] > (tc[i] >> 1);
        end
    end

    // Handshake decode: accept only into an empty slot, commit at a safe point.
    always_comb begin
        accept = cfg_valid && !pend_v;
        apply  = pend_v && (sync_clr || !en[pend_ch] || wrap[pend_ch]);
    end

    // Channel counters, terminal counts and outputs.
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
                tc[i]  <= DEFAULT_TC;
            end
            tick    <= '0;
            clk_out <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt[i] <= cnt_nxt[i];
                if (apply && (pend_ch == CH_W'(i))) begin
                    tc[i] <= pend_tc;
                end
            end
            tick    <= tick_nxt;
            clk_out <= clk_nxt;
        end
    end

    // Pending configuration slot; out-of-range channels are accepted and dropped.
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            pend_v  <= 1'b0;
            pend_ch <= '0;
            pend_tc <= '0;
        end else if (accept) begin
            pend_v  <= ({1'b0, cfg_ch} < NUM_CH_L);
            pend_ch <= cfg_ch;
            pend_tc <= (cfg_tc == '0) ? CNT_W'(1) : cfg_tc;
        end else if (apply) begin
            pend_v  <= 1'b0;
        end
    end

endmodule
